rate_change_cfg_sequencer: RTL and testbench

//  Reconfiguration controller for axi_rate_change. Accepts a new N:M rate request, gates the

---
 rtl/rate_change_cfg_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_rate_change_cfg_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rate_change_cfg_sequencer.sv
// Reconfiguration sequencer for axi_rate_change: closes the input at an EOB boundary,
// drains in-flight bursts, pulses clear, then writes N, M and CONFIG over the settings bus.
module rate_change_cfg_sequencer #(
  parameter int MAX_N          = 16,
  parameter int MAX_M          = 16,
  parameter int SR_N_ADDR      = 0,
  parameter int SR_M_ADDR      = 1,
  parameter int SR_CONFIG_ADDR = 2,
  parameter int CLEAR_CYCLES   = 2,
  parameter int DRAIN_TIMEOUT  = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cfg_n,
  input  logic [15:0] cfg_m,
  input  logic [31:0] cfg_word,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  output logic        cfg_err,
  output logic        busy,
  input  logic        in_tvalid,
  output logic        in_tready,
  input  logic        in_tlast,
  input  logic        in_eob,
  output logic        dut_tvalid,
  input  logic        dut_tready,
  input  logic        out_tvalid,
  input  logic        out_tready,
  input  logic        out_tlast,
  input  logic        out_eob,
  output logic        clear,
  output logic        set_stb,
  output logic [7:0]  set_addr,
  output logic [31:0] set_data
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRAIN  = 3'd1;
  localparam logic [2:0] S_CLEAR  = 3'd2;
  localparam logic [2:0] S_WR_N   = 3'd3;
  localparam logic [2:0] S_WR_M   = 3'd4;
  localparam logic [2:0] S_WR_CFG = 3'd5;
  localparam logic [2:0] S_SETTLE = 3'd6;

  localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam int TO_W  = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(DRAIN_TIMEOUT - 1);
  localparam logic [15:0] MAX_N16  = 16'(MAX_N);
  localparam logic [15:0] MAX_M16  = 16'(MAX_M);
  localparam logic [7:0]  ADDR_N   = 8'(SR_N_ADDR);
  localparam logic [7:0]  ADDR_M   = 8'(SR_M_ADDR);
  localparam logic [7:0]  ADDR_CFG = 8'(SR_CONFIG_ADDR);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CLR_W-1:0] clr_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [7:0]       inflight;
  logic             in_burst;
  logic             cfg_loaded;
  logic [15:0]      n_lat;
  logic [15:0]      m_lat;
  logic [31:0]      word_lat;

  logic open_gate;
  logic in_acc;
  logic eob_in;
  logic eob_out;
  logic out_beat;
  logic cfg_acc;
  logic cfg_bad;
  logic drain_done;
  logic drain_to;

  function automatic logic [7:0] sat_step(input logic [7:0] v, input logic inc, input logic dec);
    logic [7:0] r;
    r = v;
    if (inc && !dec && (v != 8'hFF))
      r = v + 8'd1;
    else if (dec && !inc && (v != 8'h00))
      r = v - 8'd1;
    return r;
  endfunction

  function automatic logic out_of_range(input logic [15:0] n, input logic [15:0] m);
    return (n == 16'd0) || (n > MAX_N16) || (m == 16'd0) || (m > MAX_M16);
  endfunction

  // Input gate: open while idle, and while draining only until the current burst ends
  assign open_gate  = (state == S_IDLE) || ((state == S_DRAIN) && in_burst);
  assign in_tready  = dut_tready & open_gate;
  assign dut_tvalid = in_tvalid & open_gate;
  assign in_acc     = in_tvalid & in_tready;
  assign eob_in     = in_acc & in_tlast & in_eob;
  assign out_beat   = out_tvalid & out_tready;
  assign eob_out    = out_beat & out_tlast & out_eob;

  assign cfg_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign clear      = (state == S_CLEAR);
  assign cfg_acc    = cfg_valid & cfg_ready;
  assign cfg_bad    = out_of_range(cfg_n, cfg_m);
  assign drain_done = !in_burst && (inflight == 8'd0);
  assign drain_to   = !out_beat && (to_cnt == TO_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (cfg_acc && !cfg_bad) state_nxt = S_DRAIN;
      S_DRAIN:  if (drain_done || drain_to) state_nxt = S_CLEAR;
      // The clear that follows reset has nothing to write yet
      S_CLEAR:  if (clr_cnt == CLR_LAST) state_nxt = cfg_loaded ? S_WR_N : S_IDLE;
      S_WR_N:   state_nxt = S_WR_M;
      S_WR_M:   state_nxt = S_WR_CFG;
      S_WR_CFG: state_nxt = S_SETTLE;
      S_SETTLE: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_CLEAR;
      clr_cnt    <= '0;
      to_cnt     <= '0;
      inflight   <= 8'd0;
      in_burst   <= 1'b0;
      cfg_err    <= 1'b0;
      cfg_loaded <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == S_CLEAR)
        clr_cnt <= (clr_cnt == CLR_LAST) ? '0 : clr_cnt + 1'b1;
      else
        clr_cnt <= '0;

      // Counts consecutive drain cycles without an output beat
      if ((state == S_DRAIN) && !out_beat)
        to_cnt <= to_cnt + 1'b1;
      else
        to_cnt <= '0;

      if (state == S_CLEAR)
        inflight <= 8'd0;
      else
        inflight <= sat_step(inflight, eob_in, eob_out);

      if (in_acc)
        in_burst <= !(in_tlast && in_eob);

      if (cfg_acc)
        cfg_err <= cfg_bad;
      else if ((state == S_DRAIN) && !drain_done && drain_to)
        cfg_err <= 1'b1;

      if (cfg_acc && !cfg_bad)
        cfg_loaded <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_acc) begin
      n_lat    <= cfg_n;
      m_lat    <= cfg_m;
      word_lat <= cfg_word;
    end
  end

  always_comb begin
    set_stb  = 1'b0;
    set_addr = 8'd0;
    set_data = 32'd0;
    case (state)
      S_WR_N: begin
        set_stb  = 1'b1;
        set_addr = ADDR_N;
        set_data = {16'd0, n_lat};
      end
      S_WR_M: begin
        set_stb  = 1'b1;
        set_addr = ADDR_M;
        set_data = {16'd0, m_lat};
      end
      S_WR_CFG: begin
        set_stb  = 1'b1;
        set_addr = ADDR_CFG;
        set_data = word_lat;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rate_change_cfg_sequencer.sv
// Bench for rate_change_cfg_sequencer: a queue-based behavioural model checked against
// every output each cycle, plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_rate_change_cfg_sequencer;
  localparam int CL   = 2;
  localparam int TO   = 32;
  localparam int MAXN = 16;
  localparam int MAXM = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cfg_n = '0, cfg_m = '0;
  logic [31:0] cfg_word = '0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready, cfg_err, busy;
  logic        in_tvalid = 1'b0, in_tlast = 1'b0, in_eob = 1'b0;
  logic        in_tready, dut_tvalid;
  logic        dut_tready = 1'b0;
  logic        out_tvalid = 1'b0, out_tready = 1'b0, out_tlast = 1'b0, out_eob = 1'b0;
  logic        clear, set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;

  always #5 clk = ~clk;

  rate_change_cfg_sequencer #(
    .MAX_N(MAXN), .MAX_M(MAXM), .SR_N_ADDR(0), .SR_M_ADDR(1), .SR_CONFIG_ADDR(2),
    .CLEAR_CYCLES(CL), .DRAIN_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .cfg_n(cfg_n), .cfg_m(cfg_m), .cfg_word(cfg_word),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_err(cfg_err), .busy(busy),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tlast(in_tlast), .in_eob(in_eob),
    .dut_tvalid(dut_tvalid), .dut_tready(dut_tready), .out_tvalid(out_tvalid),
    .out_tready(out_tready), .out_tlast(out_tlast), .out_eob(out_eob), .clear(clear),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data)
  );

  int n_vec = 0;
  int n_err = 0;
  int beats_acc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the post-drain sequence is a queue of per-cycle output records
  typedef struct packed {
    logic        clr;
    logic        stb;
    logic [7:0]  addr;
    logic [31:0] data;
  } rec_t;

  rec_t        seq_q[$];
  bit          m_drain, m_burst, m_err;
  int          m_infl, m_quiet;
  logic [15:0] m_n, m_m;
  logic [31:0] m_word;

  function automatic void model_reset();
    seq_q.delete();
    for (int i = 0; i < CL; i++) seq_q.push_back('{1'b1, 1'b0, 8'd0, 32'd0});
    m_drain = 0; m_burst = 0; m_err = 0; m_infl = 0; m_quiet = 0;
  endfunction

  function automatic void push_sequence();
    for (int i = 0; i < CL; i++) seq_q.push_back('{1'b1, 1'b0, 8'd0, 32'd0});
    seq_q.push_back('{1'b0, 1'b1, 8'd0, {16'd0, m_n}});
    seq_q.push_back('{1'b0, 1'b1, 8'd1, {16'd0, m_m}});
    seq_q.push_back('{1'b0, 1'b1, 8'd2, m_word});
    seq_q.push_back('{1'b0, 1'b0, 8'd0, 32'd0});
  endfunction

  initial model_reset();

  always @(posedge clk) if (!reset && in_tvalid && in_tready) beats_acc++;

  always @(negedge clk) begin
    bit idle, open, acc, inc, dec, bad, old_burst;
    int old_infl;
    rec_t r;
    if (reset) begin
      model_reset();
      chk("rst_busy", busy, 1);
      chk("rst_cfg_ready", cfg_ready, 0);
      chk("rst_clear", clear, 1);
      chk("rst_set_stb", set_stb, 0);
      chk("rst_set_addr", set_addr, 0);
      chk("rst_set_data", set_data, 0);
      chk("rst_cfg_err", cfg_err, 0);
      chk("rst_in_tready", in_tready, 0);
    end else begin
      idle = !m_drain && (seq_q.size() == 0);
      open = idle || (m_drain && m_burst);
      r    = (seq_q.size() > 0) ? seq_q[0] : rec_t'(0);
      chk("cfg_ready", cfg_ready, idle);
      chk("busy", busy, !idle);
      chk("cfg_err", cfg_err, m_err);
      chk("in_tready", in_tready, dut_tready && open);
      chk("dut_tvalid", dut_tvalid, in_tvalid && open);
      chk("clear", clear, r.clr);
      chk("set_stb", set_stb, r.stb);
      chk("set_addr", set_addr, r.addr);
      chk("set_data", set_data, r.data);

      acc = in_tvalid && dut_tready && open;
      inc = acc && in_tlast && in_eob;
      dec = out_tvalid && out_tready && out_tlast && out_eob;
      old_infl  = m_infl;
      old_burst = m_burst;
      if (acc) m_burst = !(in_tlast && in_eob);
      if (r.clr) m_infl = 0;
      else begin
        m_infl = m_infl + int'(inc) - int'(dec);
        if (m_infl < 0) m_infl = 0;
        if (m_infl > 255) m_infl = 255;
      end

      if (seq_q.size() > 0) begin
        void'(seq_q.pop_front());
      end else if (m_drain) begin
        m_quiet = (out_tvalid && out_tready) ? 0 : m_quiet + 1;
        if (!old_burst && old_infl == 0) begin
          m_drain = 0;
          push_sequence();
        end else if (m_quiet >= TO) begin
          m_drain = 0;
          m_err = 1;
          push_sequence();
        end
      end else if (cfg_valid) begin
        bad = (cfg_n == 0) || (cfg_n > MAXN) || (cfg_m == 0) || (cfg_m > MAXM);
        m_err = bad;
        if (!bad) begin
          m_drain = 1; m_quiet = 0;
          m_n = cfg_n; m_m = cfg_m; m_word = cfg_word;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int g = 0;
    @(negedge clk);
    while (busy && g < 200) begin
      cyc();
      @(negedge clk);
      g++;
    end
    chk(name, busy, 0);
    cyc();
  endtask

  task automatic send_beat(input bit last, input bit eob, input bit req);
    bit done = 0;
    int guard = 0;
    in_tvalid = 1; in_tlast = last; in_eob = eob;
    if (req) begin
      cfg_valid = 1; cfg_n = 16'd5; cfg_m = 16'd3; cfg_word = 32'h1234_5678;
    end
    dut_tready = ($urandom_range(0, 3) != 0);
    while (!done) begin
      @(negedge clk);
      if (in_tready) done = 1;
      else if (guard > 200) begin
        chk("beat_timeout", 0, 1);
        done = 1;
      end else begin
        guard++;
        cyc();
        cfg_valid = 0;
        dut_tready = ($urandom_range(0, 3) != 0);
      end
    end
    cyc();
    in_tvalid = 0; in_tlast = 0; in_eob = 0; cfg_valid = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, stray;
    bit found, seen;

    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk); chk("post_rst_clear0", clear, 1);
    @(negedge clk); chk("post_rst_clear1", clear, 1);
    @(negedge clk); chk("post_rst_idle", cfg_ready, 1); chk("post_rst_no_stb", set_stb, 0);

    // Request 3:2 on an idle pipe
    cyc();
    cfg_n = 16'd3; cfg_m = 16'd2; cfg_word = 32'hCAFE_0123; cfg_valid = 1;
    @(negedge clk); chk("t1_ready", cfg_ready, 1);
    cyc(); cfg_valid = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("t1_clear", clear, (k == 2 || k == 3));
      chk("t1_stb", set_stb, (k >= 4 && k <= 6));
      chk("t1_busy", busy, (k <= 7));
      if (k == 4) begin chk("t1_addr_n", set_addr, 0); chk("t1_data_n", set_data, 3); end
      if (k == 5) begin chk("t1_addr_m", set_addr, 1); chk("t1_data_m", set_data, 2); end
      if (k == 6) begin chk("t1_addr_c", set_addr, 2); chk("t1_data_c", set_data, 32'hCAFE_0123); end
      cyc();
    end

    // Request mid-burst: three 16-beat packets, EOB on the third
    b0 = beats_acc;
    out_tvalid = 1; out_tready = 1; out_tlast = 0; out_eob = 0;
    for (int p = 0; p < 3; p++)
      for (int b = 0; b < 16; b++)
        send_beat(b == 15, p == 2, (p == 0 && b == 5));
    dut_tready = 1; out_tvalid = 0;
    @(negedge clk); chk("t2_gate_closed", in_tready, 0); chk("t2_busy", busy, 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      @(negedge clk); chk("t2_no_early_clear", clear, 0);
    end
    cyc(); out_tvalid = 1; out_tready = 1; out_tlast = 1; out_eob = 1;
    cyc(); out_tvalid = 0; out_tlast = 0; out_eob = 0;
    seen = 0;
    for (int g = 0; g < 10 && !seen; g++) begin
      @(negedge clk); seen = clear;
      cyc();
    end
    chk("t2_clear_after_eob", seen, 1);
    chk("t2_beats", beats_acc - b0, 48);
    wait_idle("t2_idle");

    // Out-of-range requests
    cyc(); cfg_valid = 1; cfg_n = 16'd0; cfg_m = 16'd2;
    cyc(); cfg_valid = 0;
    @(negedge clk); chk("t3_err_n0", cfg_err, 1); chk("t3_idle_n0", busy, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(); @(negedge clk); chk("t3_no_stb", set_stb, 0); chk("t3_no_clear", clear, 0);
    end
    cyc(); cfg_valid = 1; cfg_n = 16'd4; cfg_m = 16'd17;
    cyc(); cfg_valid = 0;
    @(negedge clk); chk("t3_err_m17", cfg_err, 1); chk("t3_idle_m17", busy, 0);
    cyc(); cfg_valid = 1; cfg_n = 16'd4; cfg_m = 16'd16; cfg_word = 32'h0000_00A5;
    cyc(); cfg_valid = 0;
    @(negedge clk); chk("t3_err_cleared", cfg_err, 0); chk("t3_busy", busy, 1);
    cyc();
    wait_idle("t3_idle");

    // Drain timeout with the output stalled
    dut_tready = 1; out_tvalid = 1; out_tready = 0;
    in_tvalid = 1; in_tlast = 1; in_eob = 1;
    cyc(); in_tvalid = 0; in_tlast = 0; in_eob = 0;
    cfg_valid = 1; cfg_n = 16'd2; cfg_m = 16'd2; cfg_word = 32'h0BAD_F00D;
    cyc(); cfg_valid = 0;
    for (int k = 1; k <= TO + 1; k++) begin
      @(negedge clk);
      chk("t4_clear", clear, (k == TO + 1));
      if (k == TO + 1) chk("t4_err", cfg_err, 1);
      if (k <= TO) cyc();
    end
    cyc();
    wait_idle("t4_idle");
    chk("t4_err_sticky", cfg_err, 1);
    out_tvalid = 0;

    // Back-to-back requests 1:1 then 16:1, second held while busy
    cfg_valid = 1; cfg_n = 16'd1; cfg_m = 16'd1; cfg_word = 32'h11;
    cyc(); cfg_n = 16'd16; cfg_m = 16'd1; cfg_word = 32'h161;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); chk("t5_ready", cfg_ready, (k == 8));
      cyc();
    end
    cfg_valid = 0;
    wait_idle("t5_idle");

    // Randomised traffic, requests and output stalls
    for (int c = 0; c < 3000; c++) begin
      in_tvalid  = $urandom_range(0, 1);
      in_tlast   = ($urandom_range(0, 7) == 0);
      in_eob     = $urandom_range(0, 1);
      dut_tready = ($urandom_range(0, 3) != 0);
      out_tvalid = (c < 1500) ? $urandom_range(0, 1) : ($urandom_range(0, 63) == 0);
      out_tready = ($urandom_range(0, 3) != 0);
      out_tlast  = ($urandom_range(0, 3) == 0);
      out_eob    = $urandom_range(0, 1);
      cfg_valid  = ($urandom_range(0, 15) == 0);
      cfg_n      = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 40)) : 16'($urandom_range(1, 16));
      cfg_m      = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 40)) : 16'($urandom_range(1, 16));
      cfg_word   = $urandom;
      cyc();
    end
    in_tvalid = 0; cfg_valid = 0; out_tvalid = 0;
    wait_idle("t6_idle");

    // Reset during the M write
    dut_tready = 1; in_tvalid = 1;
    cfg_valid = 1; cfg_n = 16'd7; cfg_m = 16'd9; cfg_word = 32'hDEAD_BEEF;
    cyc(); cfg_valid = 0; in_tvalid = 0;
    found = 0;
    for (int g = 0; g < 100 && !found; g++) begin
      @(negedge clk);
      found = set_stb && (set_addr == 8'd1);
      if (!found) cyc();
    end
    chk("t7_reach_wr_m", found, 1);
    in_tvalid = 1;
    #1 reset = 1;
    #1;
    chk("t7_cfg_ready", cfg_ready, 0);
    chk("t7_busy", busy, 1);
    chk("t7_clear", clear, 1);
    chk("t7_stb", set_stb, 0);
    chk("t7_addr", set_addr, 0);
    chk("t7_data", set_data, 0);
    chk("t7_in_tready", in_tready, 0);
    chk("t7_cfg_err", cfg_err, 0);
    repeat (2) cyc();
    reset = 0; in_tvalid = 0;
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); if (set_stb) stray++;
      cyc();
    end
    chk("t7_no_stray_stb", stray, 0);
    chk("t7_idle_after", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
